// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing helpers for the IF/LS memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_e;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;
    localparam int unsigned ARB_CNT_W           = $clog2(ARB_TIMEOUT_DEFAULT + 1);

    // Counter width able to hold the value "limit".
    function automatic int unsigned arb_cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Transfer watchdog: counts cycles while a transfer is in flight and flags
// the cycle in which the limit is reached. Used only with MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = arb_cnt_width(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Count busy cycles; any idle cycle clears the count.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th consecutive busy cycle.
    assign expired = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction
// fetch (IF) and load/store (LS); one outstanding transfer at a time.
// Optional macro MEM_ARB_TIMEOUT_EN enables a transfer watchdog that ends a
// stuck transfer with err=1 after TIMEOUT_CYCLES cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_busy
);

    arb_state_e state;
    arb_owner_e owner;
    arb_owner_e last_owner;
    logic       pick_ls;
    logic       done;
    logic       tmo;

    // LS wins when it is alone, or on a tie when IF was served last.
    assign pick_ls = ls_req && (!if_req || (last_owner == OWN_IF));

    // Normal completion, including gnt and rvalid in the same REQ cycle.
    assign done = ((state == ARB_REQ) && mem_gnt && mem_rvalid) ||
                  ((state == ARB_WAIT) && mem_rvalid);

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state != ARB_IDLE),
        .expired (expired)
    );

    // A real completion in the expiry cycle takes priority over the timeout.
    assign tmo = expired && !done;
`else
    assign tmo = 1'b0;
`endif

    // Arbitration FSM with registered grant/response/memory outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_LS;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            ls_gnt     <= 1'b0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            ls_err     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            arb_busy   <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_err    <= 1'b0;
            ls_err    <= 1'b0;

            if (done || tmo) begin
                state      <= ARB_IDLE;
                mem_req    <= 1'b0;
                arb_busy   <= 1'b0;
                last_owner <= owner;
                if (owner == OWN_IF) begin
                    if_rvalid <= 1'b1;
                    if_err    <= tmo;
                    if_rdata  <= tmo ? '0 : mem_rdata;
                end else begin
                    ls_rvalid <= 1'b1;
                    ls_err    <= tmo;
                    ls_rdata  <= (tmo || mem_we) ? '0 : mem_rdata;
                end
            end else begin
                case (state)
                    ARB_IDLE: begin
                        if (if_req || ls_req) begin
                            if (pick_ls) begin
                                owner     <= OWN_LS;
                                ls_gnt    <= 1'b1;
                                mem_we    <= ls_we;
                                mem_addr  <= ls_addr;
                                mem_wdata <= ls_wdata;
                                mem_be    <= ls_be;
                            end else begin
                                owner     <= OWN_IF;
                                if_gnt    <= 1'b1;
                                mem_we    <= 1'b0;
                                mem_addr  <= if_addr;
                                mem_wdata <= '0;
                                mem_be    <= '1;
                            end
                            mem_req  <= 1'b1;
                            arb_busy <= 1'b1;
                            state    <= ARB_REQ;
                        end
                    end
                    ARB_REQ: begin
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            state   <= ARB_WAIT;
                        end
                    end
                    ARB_WAIT: begin
                    end
                    default: begin
                        state    <= ARB_IDLE;
                        mem_req  <= 1'b0;
                        arb_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Define MEM_ARB_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        arb_busy;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_be      (ls_be),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .arb_busy   (arb_busy)
    );

    // Advance one cycle; outputs are observed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0;
        ls_addr = '0; ls_wdata = '0; ls_be = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        tick(); tick();
        tests++; if ({if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we, arb_busy} !== 9'b0) begin
            failed++; $display("FAIL reset_ctrl: got %b expected 0", {if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we, arb_busy}); end
        tests++; if ({if_rdata, ls_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin
            failed++; $display("FAIL reset_data: nonzero data outputs after reset"); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 32'h0000_0010;
        tick();
        tests++; if ({if_gnt, ls_gnt, mem_req, mem_we, arb_busy} !== 5'b10101) begin
            failed++; $display("FAIL fetch_gnt: got %b expected 10101", {if_gnt, ls_gnt, mem_req, mem_we, arb_busy}); end
        tests++; if (mem_addr !== 32'h10 || mem_be !== 4'hF) begin
            failed++; $display("FAIL fetch_mem: addr %h be %h expected 00000010 f", mem_addr, mem_be); end
        if_req = 0; mem_gnt = 1;
        tick();
        tests++; if ({mem_req, if_gnt, if_rvalid, arb_busy} !== 4'b0001) begin
            failed++; $display("FAIL fetch_wait: got %b expected 0001", {mem_req, if_gnt, if_rvalid, arb_busy}); end
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0093;
        tick();
        mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
        tests++; if ({if_rvalid, if_err, ls_rvalid, arb_busy} !== 4'b1000 || if_rdata !== 32'h93) begin
            failed++; $display("FAIL fetch_rvalid: flags %b rdata %h expected 1000 00000093", {if_rvalid, if_err, ls_rvalid, arb_busy}, if_rdata); end
        tick();
        tests++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h93) begin
            failed++; $display("FAIL fetch_hold: rvalid %b rdata %h expected 0 00000093", if_rvalid, if_rdata); end
    endtask

    task automatic test_store();
        ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
        tick();
        tests++; if ({ls_gnt, if_gnt, mem_req, mem_we} !== 4'b1011 || mem_be !== 4'b0011) begin
            failed++; $display("FAIL store_gnt: flags %b be %b expected 1011 0011", {ls_gnt, if_gnt, mem_req, mem_we}, mem_be); end
        tests++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            failed++; $display("FAIL store_mem: addr %h wdata %h expected 00000100 deadbeef", mem_addr, mem_wdata); end
        ls_req = 0; ls_addr = 32'h200; ls_we = 0;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_gnt = 0; mem_rvalid = 0;
        tests++; if ({ls_rvalid, ls_err, if_rvalid, mem_req, arb_busy} !== 5'b10000 || ls_rdata !== '0) begin
            failed++; $display("FAIL store_ack: flags %b rdata %h expected 10000 00000000", {ls_rvalid, ls_err, if_rvalid, mem_req, arb_busy}, ls_rdata); end
        tick();
    endtask

    task automatic test_round_robin();
        if_req = 1; if_addr = 32'h400; ls_req = 1; ls_we = 0; ls_addr = 32'h800; ls_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if ({if_gnt, ls_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                failed++; $display("FAIL rr_gnt%0d: got %b expected %b", k, {if_gnt, ls_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            mem_gnt = 1;
            tick();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA000_0000 + k;
            tick();
            mem_rvalid = 0;
            tests++; if ({if_rvalid, ls_rvalid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                failed++; $display("FAIL rr_rvalid%0d: got %b expected %b", k, {if_rvalid, ls_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01); end
        end
        if_req = 0; ls_req = 0;
        tick();
        tests++; if (arb_busy !== 1'b0 || ls_rdata !== 32'hA000_0003) begin
            failed++; $display("FAIL rr_end: busy %b ls_rdata %h expected 0 a0000003", arb_busy, ls_rdata); end
    endtask

    task automatic test_delayed_gnt();
        if_req = 1; if_addr = 32'h40;
        tick();
        if_req = 0; if_addr = 32'hFFFF;
        for (int i = 0; i < 5; i++) begin
            mem_gnt = 0; mem_rvalid = (i == 2); mem_rdata = 32'hBAD0_0000;
            tick();
            tests++; if ({mem_req, arb_busy, if_rvalid} !== 3'b110 || mem_addr !== 32'h40) begin
                failed++; $display("FAIL stall%0d: flags %b addr %h expected 110 00000040", i, {mem_req, arb_busy, if_rvalid}, mem_addr); end
        end
        mem_rvalid = 0; mem_gnt = 1;
        tick();
        tests++; if ({mem_req, arb_busy} !== 2'b01) begin
            failed++; $display("FAIL stall_gnt: got %b expected 01", {mem_req, arb_busy}); end
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_00A5;
        tick();
        mem_rvalid = 0;
        tests++; if ({if_rvalid, arb_busy} !== 2'b10 || if_rdata !== 32'hA5) begin
            failed++; $display("FAIL stall_done: flags %b rdata %h expected 10 000000a5", {if_rvalid, arb_busy}, if_rdata); end
        mem_rvalid = 1; mem_rdata = 32'h0000_0077;
        tick();
        mem_rvalid = 0;
        tick();
        tests++; if ({if_rvalid, ls_rvalid, arb_busy} !== 3'b000 || if_rdata !== 32'hA5) begin
            failed++; $display("FAIL idle_rvalid: flags %b rdata %h expected 000 000000a5", {if_rvalid, ls_rvalid, arb_busy}, if_rdata); end
    endtask

    task automatic test_reset_mid();
        ls_req = 1; ls_we = 0; ls_addr = 32'h300;
        tick();
        ls_req = 0; mem_gnt = 1;
        tick();
        mem_gnt = 0; rst = 1;
        tick();
        tests++; if ({arb_busy, mem_req, ls_rvalid, if_rvalid} !== 4'b0000) begin
            failed++; $display("FAIL rst_wait: got %b expected 0000", {arb_busy, mem_req, ls_rvalid, if_rvalid}); end
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h55;
        tick();
        mem_rvalid = 0;
        tick();
        tests++; if ({arb_busy, mem_req, ls_rvalid, if_rvalid} !== 4'b0000 || ls_rdata !== '0) begin
            failed++; $display("FAIL rst_late_rvalid: flags %b rdata %h expected 0000 00000000", {arb_busy, mem_req, ls_rvalid, if_rvalid}, ls_rdata); end
        if_req = 1; if_addr = 32'h20;
        tick();
        if_req = 0; rst = 1;
        tick();
        rst = 0;
        tests++; if ({mem_req, arb_busy, if_gnt} !== 3'b000) begin
            failed++; $display("FAIL rst_req: got %b expected 000", {mem_req, arb_busy, if_gnt}); end
        tick();
    endtask

    task automatic test_timeout();
        int unsigned waited;
        ls_req = 1; ls_we = 0; ls_addr = 32'h80;
        tick();
        ls_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        tick();
        mem_gnt = 0; mem_rvalid = 0;
        tests++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h77) begin
            failed++; $display("FAIL load: rvalid %b rdata %h expected 1 00000077", ls_rvalid, ls_rdata); end
        tick();
        ls_req = 1; ls_addr = 32'h84;
        tick();
        ls_req = 0;
        waited = 0;
        while (ls_rvalid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        tests++; if (waited !== 8 || {ls_rvalid, ls_err, mem_req, arb_busy} !== 4'b1100 || ls_rdata !== '0) begin
            failed++; $display("FAIL timeout: waited %0d flags %b rdata %h expected 8 1100 00000000", waited, {ls_rvalid, ls_err, mem_req, arb_busy}, ls_rdata); end
        tick();
        if_req = 1; if_addr = 32'h30;
        tick();
        if_req = 0;
        tests++; if ({if_gnt, mem_req, ls_err} !== 3'b110) begin
            failed++; $display("FAIL timeout_regrant: got %b expected 110", {if_gnt, mem_req, ls_err}); end
`else
        tests++; if (waited !== 20 || {ls_rvalid, ls_err, mem_req, arb_busy} !== 4'b0011) begin
            failed++; $display("FAIL no_timeout: waited %0d flags %b expected 20 0011", waited, {ls_rvalid, ls_err, mem_req, arb_busy}); end
`endif
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_round_robin();
        test_delayed_gnt();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
